// File: rtl/lidar_pkg.sv
// Shared constants and FSM state type for the LiDAR scan buffer.
// Bins are whole degrees; angles arrive in 1/64-degree units.
package lidar_pkg;

    localparam int NUM_BINS         = 360;
    localparam int ANGLE_FRAC_BITS  = 6;
    localparam int ANGLE_FULL_SCALE = 23040;
    localparam int BIN_W            = 9;
    localparam int DIST_W           = 16;
    localparam int WRAP_HI_BIN      = 270;
    localparam int WRAP_LO_BIN      = 90;

    typedef enum logic [2:0] {
        INIT_CLEAR,
        IDLE,
        RD,
        WR,
        SWAP_CLEAR
    } state_t;

    // A scan is complete when the sweep jumps from the last quadrant into the first.
    function automatic logic is_wrap(input logic prev_valid,
                                     input logic [BIN_W-1:0] prev_bin,
                                     input logic [BIN_W-1:0] next_bin);
        return prev_valid && (prev_bin >= BIN_W'(WRAP_HI_BIN)) &&
               (next_bin < BIN_W'(WRAP_LO_BIN));
    endfunction

endpackage

// File: rtl/scan_bank_ram.sv
// Two NUM_BINS x DIST_W banks: a read/write port on the active bank for
// read-modify-write and clearing, and a registered read port on the published bank.
module scan_bank_ram
    import lidar_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              act_bank,
    input  logic              act_we,
    input  logic              act_both,
    input  logic [BIN_W-1:0]  act_addr,
    input  logic [DIST_W-1:0] act_wdata,
    output logic [DIST_W-1:0] act_rdata,
    input  logic              pub_bank,
    input  logic [BIN_W-1:0]  pub_addr,
    output logic [DIST_W-1:0] pub_rdata
);

    logic [DIST_W-1:0] bank0 [NUM_BINS];
    logic [DIST_W-1:0] bank1 [NUM_BINS];

    always_ff @(posedge clk) begin
        if (act_we && (act_both || !act_bank))
            bank0[act_addr] <= act_wdata;
        if (act_we && (act_both || act_bank))
            bank1[act_addr] <= act_wdata;
        act_rdata <= act_bank ? bank1[act_addr] : bank0[act_addr];
    end

    // Addresses past the last bin have no storage behind them and read as empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pub_rdata <= '0;
        else if (pub_addr >= BIN_W'(NUM_BINS))
            pub_rdata <= '0;
        else
            pub_rdata <= pub_bank ? bank1[pub_addr] : bank0[pub_addr];
    end

endmodule

// File: rtl/lidar_scan_buffer.sv
// Bins parser samples into a per-degree nearest-return map, double-buffered:
// the active bank fills while the last complete scan is published for reading.
module lidar_scan_buffer
    import lidar_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 new_data_in,
    input  logic [15:0]          angle_in,
    input  logic [15:0]          distance_in,
    input  logic [8:0]           rd_addr_in,
    output logic [15:0]          rd_data_out,
    output logic                 scan_done_out,
    output logic [CNT_WIDTH-1:0] scan_count_out,
    output logic [CNT_WIDTH-1:0] drop_count_out,
    output logic                 bank_sel_out,
    output logic                 ready_out
);

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

    state_t              state;
    logic                hold_full;
    logic [BIN_W-1:0]    hold_bin;
    logic [DIST_W-1:0]   hold_dist;
    logic                prev_valid;
    logic [BIN_W-1:0]    prev_bin;
    logic [BIN_W-1:0]    clr_addr;

    logic                strobe, illegal, busy, drop, capture, wrap, clearing;
    logic [BIN_W-1:0]    in_bin;
    logic                act_we;
    logic [BIN_W-1:0]    act_addr;
    logic [DIST_W-1:0]   act_wdata, act_rdata;

    // The holding register may be refilled in the same cycle WR drains it.
    assign strobe   = new_data_in && (distance_in != '0);
    assign illegal  = angle_in >= 16'(ANGLE_FULL_SCALE);
    assign busy     = hold_full && (state != WR);
    assign drop     = strobe && (illegal || (state == INIT_CLEAR) || busy);
    assign capture  = strobe && !drop;
    assign in_bin   = angle_in[ANGLE_FRAC_BITS +: BIN_W];
    assign wrap     = is_wrap(prev_valid, prev_bin, hold_bin);
    assign clearing = (state == INIT_CLEAR) || (state == SWAP_CLEAR);

    // Keep the nearest return: empty bins take any sample, others only a closer one.
    assign act_addr  = clearing ? clr_addr : hold_bin;
    assign act_wdata = clearing ? '0 : hold_dist;
    assign act_we    = clearing ||
                       ((state == WR) && ((act_rdata == '0) || (hold_dist < act_rdata)));

    scan_bank_ram u_ram (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .act_bank  (~bank_sel_out),
        .act_we    (act_we),
        .act_both  (state == INIT_CLEAR),
        .act_addr  (act_addr),
        .act_wdata (act_wdata),
        .act_rdata (act_rdata),
        .pub_bank  (bank_sel_out),
        .pub_addr  (rd_addr_in),
        .pub_rdata (rd_data_out)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= INIT_CLEAR;
            clr_addr       <= '0;
            hold_full      <= 1'b0;
            hold_bin       <= '0;
            hold_dist      <= '0;
            prev_valid     <= 1'b0;
            prev_bin       <= '0;
            scan_done_out  <= 1'b0;
            scan_count_out <= '0;
            drop_count_out <= '0;
            bank_sel_out   <= 1'b0;
            ready_out      <= 1'b0;
        end else begin
            scan_done_out <= 1'b0;
            if (drop && (drop_count_out != '1))
                drop_count_out <= drop_count_out + 1'b1;

            case (state)
                INIT_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == LAST_BIN) begin
                        clr_addr  <= '0;
                        ready_out <= 1'b1;
                        state     <= IDLE;
                    end
                end
                IDLE: begin
                    if (hold_full) begin
                        if (wrap) begin
                            bank_sel_out   <= ~bank_sel_out;
                            scan_done_out  <= 1'b1;
                            scan_count_out <= scan_count_out + 1'b1;
                            prev_bin       <= hold_bin;
                            clr_addr       <= '0;
                            state          <= SWAP_CLEAR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: state <= WR;
                WR: begin
                    hold_full  <= 1'b0;
                    prev_bin   <= hold_bin;
                    prev_valid <= 1'b1;
                    state      <= IDLE;
                end
                SWAP_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == LAST_BIN) begin
                        clr_addr <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= INIT_CLEAR;
            endcase

            if (capture) begin
                hold_full <= 1'b1;
                hold_bin  <= in_bin;
                hold_dist <= distance_in;
            end
        end
    end

endmodule

// File: tb/tb_lidar_scan_buffer.sv
// Directed bench for lidar_scan_buffer: clear, nearest-return binning, bank swap,
// drops and mid-clear reset, with hand-computed expectations.
module tb_lidar_scan_buffer;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        new_data_in = 1'b0;
    logic [15:0] angle_in = '0;
    logic [15:0] distance_in = '0;
    logic [8:0]  rd_addr_in = '0;
    logic [15:0] rd_data_out;
    logic        scan_done_out;
    logic [15:0] scan_count_out;
    logic [15:0] drop_count_out;
    logic        bank_sel_out;
    logic        ready_out;

    int errors = 0;
    int checks = 0;
    int done_pulses = 0;
    int base;

    lidar_scan_buffer dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .new_data_in    (new_data_in),
        .angle_in       (angle_in),
        .distance_in    (distance_in),
        .rd_addr_in     (rd_addr_in),
        .rd_data_out    (rd_data_out),
        .scan_done_out  (scan_done_out),
        .scan_count_out (scan_count_out),
        .drop_count_out (drop_count_out),
        .bank_sel_out   (bank_sel_out),
        .ready_out      (ready_out)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) if (scan_done_out === 1'b1) done_pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] d);
        new_data_in = 1'b1;
        angle_in    = a;
        distance_in = d;
        @(negedge clk_in);
        new_data_in = 1'b0;
    endtask

    task automatic rd_check(input logic [8:0] a, input logic [15:0] e);
        rd_addr_in = a;
        @(negedge clk_in);
        check($sformatf("rd_data[%0d]", a), 32'(rd_data_out), 32'(e));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_data"},    32'(rd_data_out), 0);
        check({tag, "_scan_done"},  32'(scan_done_out), 0);
        check({tag, "_scan_count"}, 32'(scan_count_out), 0);
        check({tag, "_drop_count"}, 32'(drop_count_out), 0);
        check({tag, "_bank_sel"},   32'(bank_sel_out), 0);
        check({tag, "_ready"},      32'(ready_out), 0);
    endtask

    initial begin
        #3;
        check_all_zero("reset");
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Strobe during the initial clear is dropped; ready rises after 360 edges.
        send(16'd640, 16'd100);
        cycles(358);
        check("ready_at_359", 32'(ready_out), 0);
        check("drop_init_clear", 32'(drop_count_out), 1);
        cycles(1);
        check("ready_at_360", 32'(ready_out), 1);

        for (int a = 0; a < 360; a++) rd_check(9'(a), 16'd0);
        rd_check(9'd400, 16'd0);

        // Nearest return wins in bin 10; zero distance ignored; illegal angle dropped.
        send(16'd640, 16'd1500); cycles(3);
        send(16'd650, 16'd1200); cycles(3);
        send(16'd700, 16'd1800); cycles(3);
        send(16'd640, 16'd0);    cycles(3);
        check("drop_zero_dist", 32'(drop_count_out), 1);
        send(16'd23040, 16'd500); cycles(3);
        check("drop_illegal", 32'(drop_count_out), 2);

        // Bin 300 then bin 5 forces the first swap; same-cycle read sees old bank.
        send(16'd19200, 16'd3000); cycles(3);
        send(16'd320, 16'd55);
        rd_addr_in = 9'd10;
        @(negedge clk_in);
        check("swap1_done", 32'(scan_done_out), 1);
        check("swap1_bank", 32'(bank_sel_out), 1);
        check("swap1_count", 32'(scan_count_out), 1);
        check("swap1_read_old", 32'(rd_data_out), 0);
        @(negedge clk_in);
        check("swap1_done_drop", 32'(scan_done_out), 0);
        check("swap1_read_new", 32'(rd_data_out), 1200);
        for (int a = 0; a < 360; a++)
            rd_check(9'(a), (a == 10) ? 16'd1200 : (a == 300) ? 16'd3000 : 16'd0);
        cycles(10);

        // Full sweep into bank 0, then angle 128 wraps.
        base = done_pulses;
        for (int b = 0; b < 360; b++) begin
            send(16'(b * 64), 16'(b + 100));
            cycles(3);
        end
        check("sweep_no_swap", 32'(scan_count_out), 1);
        send(16'd128, 16'd77);
        cycles(1);
        check("swap2_done", 32'(scan_done_out), 1);
        check("swap2_count", 32'(scan_count_out), 2);
        check("swap2_bank", 32'(bank_sel_out), 0);
        cycles(1);
        check("swap2_single_pulse", 32'(done_pulses - base), 1);
        rd_check(9'd0, 16'd100);
        rd_check(9'd2, 16'd102);
        rd_check(9'd5, 16'd55);
        rd_check(9'd10, 16'd110);
        rd_check(9'd45, 16'd145);
        rd_check(9'd359, 16'd459);
        cycles(370);

        // Publish bank 1: held angle-128 sample landed after the clear.
        send(16'd19200, 16'd999); cycles(3);
        send(16'd0, 16'd44);
        cycles(1);
        check("swap3_done", 32'(scan_done_out), 1);
        check("swap3_count", 32'(scan_count_out), 3);
        check("swap3_bank", 32'(bank_sel_out), 1);
        rd_check(9'd2, 16'd77);
        rd_check(9'd10, 16'd0);
        rd_check(9'd45, 16'd0);
        rd_check(9'd300, 16'd999);
        cycles(370);

        // Back-to-back strobes, then a strobe while the FSM is in RD.
        send(16'd640, 16'd500);
        send(16'd704, 16'd400);
        check("drop_back_to_back", 32'(drop_count_out), 3);
        cycles(3);
        send(16'd640, 16'd600);
        cycles(1);
        send(16'd704, 16'd400);
        check("drop_in_rd", 32'(drop_count_out), 4);
        cycles(4);

        // Reset in the middle of a swap clear.
        send(16'd19200, 16'd1); cycles(3);
        send(16'd0, 16'd1);
        cycles(1);
        check("swap4_count", 32'(scan_count_out), 4);
        check("swap4_bank", 32'(bank_sel_out), 0);
        cycles(100);
        #2 rst_n_in = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        cycles(359);
        check("reinit_ready_359", 32'(ready_out), 0);
        cycles(1);
        check("reinit_ready_360", 32'(ready_out), 1);
        rd_check(9'd45, 16'd0);
        rd_check(9'd0, 16'd0);
        check("reinit_drop", 32'(drop_count_out), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
